// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl - match-level sequencer for BASPONG.
// Tracks both players' scores from the animation block's point pulses and
// decides when the ball is launched. It launches on the serve button or after
// an auto-serve timeout. It also flags match end and reports the winner.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   serve_btn  debounced serve button (level)
//   score1_in  player-1 point pulse
//   score2_in  player-2 point pulse
//   stop_ball  one-cycle launch pulse to the animation block
//   p1_score   player-1 score
//   p2_score   player-2 score
//   game_over  high while the match is over
//   winner     0 = player 1, 1 = player 2 (valid while game_over)
//   state_o    00 IDLE, 01 PLAY, 10 WAIT_SERVE, 11 GAME_OVER
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4,
  parameter int TICK_DIV    = 830000,
  parameter int SERVE_DELAY = 90,
  parameter int OVER_HOLD   = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serve_btn,
  input  logic               score1_in,
  input  logic               score2_in,
  output logic               stop_ball,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state_o
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HMAX = (SERVE_DELAY > OVER_HOLD) ? SERVE_DELAY : OVER_HOLD;
  localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

  localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]      SERVE_LAST = HW'(SERVE_DELAY - 1);
  localparam logic [HW-1:0]      HOLD_DONE  = HW'(OVER_HOLD);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PLAY       = 2'b01,
    WAIT_SERVE = 2'b10,
    GAME_OVER  = 2'b11
  } state_t;

  state_t             state;
  logic [TW-1:0]      tick_cnt;
  logic [HW-1:0]      hold_cnt;
  logic               serve_q, s1_q, s2_q;
  logic               armed;
  logic               tick;
  logic               serve_ev, s1_ev, s2_ev;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

  // armed is low for the first cycle after reset. A button held through
  // reset release therefore loads its history register without firing.
  always_comb begin
    tick     = (tick_cnt == TICK_LAST);
    serve_ev = armed & serve_btn & ~serve_q;
    s1_ev    = armed & score1_in & ~s1_q;
    s2_ev    = armed & score2_in & ~s2_q;
    p1_inc   = (p1_score == WIN) ? WIN : p1_score + 1'b1;
    p2_inc   = (p2_score == WIN) ? WIN : p2_score + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stop_ball <= 1'b0;
      p1_score  <= '0;
      p2_score  <= '0;
      winner    <= 1'b0;
      tick_cnt  <= '0;
      hold_cnt  <= '0;
      serve_q   <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      serve_q   <= serve_btn;
      s1_q      <= score1_in;
      s2_q      <= score2_in;
      armed     <= 1'b1;
      stop_ball <= 1'b0;
      case (state)
        IDLE: begin
          if (serve_ev) begin
            state     <= PLAY;
            stop_ball <= 1'b1;
          end
        end
        PLAY: begin
          // Player 1 wins a same-cycle tie; the player-2 point is dropped.
          if (s1_ev) begin
            p1_score <= p1_inc;
            hold_cnt <= '0;
            if (p1_inc == WIN) begin
              state  <= GAME_OVER;
              winner <= 1'b0;
            end else begin
              state <= WAIT_SERVE;
            end
          end else if (s2_ev) begin
            p2_score <= p2_inc;
            hold_cnt <= '0;
            if (p2_inc == WIN) begin
              state  <= GAME_OVER;
              winner <= 1'b1;
            end else begin
              state <= WAIT_SERVE;
            end
          end
        end
        WAIT_SERVE: begin
          if (tick) hold_cnt <= hold_cnt + 1'b1;
          // The timeout fires on the tick that brings the count to SERVE_DELAY.
          // A serve in that same cycle merges into the one launch.
          if (serve_ev || (tick && hold_cnt == SERVE_LAST)) begin
            state     <= PLAY;
            stop_ball <= 1'b1;
          end
        end
        GAME_OVER: begin
          if (serve_ev && hold_cnt == HOLD_DONE) begin
            state    <= IDLE;
            p1_score <= '0;
            p2_score <= '0;
          end else if (tick && hold_cnt != HOLD_DONE) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign game_over = (state == GAME_OVER);
  assign state_o   = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl - self-checking bench for pong_match_ctrl.
// Runs a table of directed vectors, then hand-written corner sequences, then
// random stimulus compared cycle by cycle against a reference model.
module tb_pong_match_ctrl;
  localparam int TD = 4, SD = 3, OH = 2, WS = 3, SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          serve_btn = 1'b0;
  logic          score1_in = 1'b0;
  logic          score2_in = 1'b0;
  logic          stop_ball, game_over, winner;
  logic [SW-1:0] p1_score, p2_score;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE(WS), .SCORE_W(SW), .TICK_DIV(TD), .SERVE_DELAY(SD), .OVER_HOLD(OH)
  ) dut (
    .clk(clk), .reset(reset), .serve_btn(serve_btn), .score1_in(score1_in),
    .score2_in(score2_in), .stop_ball(stop_ball), .p1_score(p1_score),
    .p2_score(p2_score), .game_over(game_over), .winner(winner), .state_o(state_o)
  );

  int checks = 0;
  int passed = 0;

  // Reference model. The state numbers follow the state_o encoding.
  // m_phase is the cycle position inside the frame period.
  // m_ticks counts the frame ticks seen in the current waiting state.
  int m_st, m_p1, m_p2, m_win, m_stop, m_phase, m_ticks;
  bit m_armed, m_psv, m_pa, m_pb;

  task automatic model_update(input bit r, input bit sv, input bit a, input bit b);
    bit tk, sev, aev, bev;
    if (r) begin
      m_st = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_stop = 0;
      m_phase = 0; m_ticks = 0; m_armed = 0; m_psv = 0; m_pa = 0; m_pb = 0;
      return;
    end
    tk  = (m_phase == TD - 1);
    sev = m_armed && sv && !m_psv;
    aev = m_armed && a && !m_pa;
    bev = m_armed && b && !m_pb;
    m_stop = 0;
    case (m_st)
      0: if (sev) begin m_st = 1; m_stop = 1; end
      1: if (aev || bev) begin
           if (aev) m_p1 = (m_p1 < WS) ? m_p1 + 1 : WS;
           else     m_p2 = (m_p2 < WS) ? m_p2 + 1 : WS;
           m_ticks = 0;
           if ((aev ? m_p1 : m_p2) == WS) begin m_st = 3; m_win = aev ? 0 : 1; end
           else m_st = 2;
         end
      2: begin
           if (tk) m_ticks++;
           if (sev || (tk && m_ticks == SD)) begin m_st = 1; m_stop = 1; end
         end
      default: begin
           if (sev && m_ticks >= OH) begin m_st = 0; m_p1 = 0; m_p2 = 0; end
           else if (tk && m_ticks < OH) m_ticks++;
         end
    endcase
    m_phase = (m_phase + 1) % TD;
    m_armed = 1; m_psv = sv; m_pa = a; m_pb = b;
  endtask

  task automatic step(input bit r, input bit sv, input bit a, input bit b);
    reset = r; serve_btn = sv; score1_in = a; score2_in = b;
    @(posedge clk);
    model_update(r, sv, a, b);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [1:0] st, input int p1,
                            input int p2, input logic stp, input logic go, input logic win);
    checks++;
    if (state_o === st && p1_score === SW'(p1) && p2_score === SW'(p2) &&
        stop_ball === stp && game_over === go && winner === win)
      passed++;
    else
      $display("FAIL %s: got st=%0d p1=%0d p2=%0d stop=%b go=%b win=%b, want st=%0d p1=%0d p2=%0d stop=%b go=%b win=%b",
               name, state_o, p1_score, p2_score, stop_ball, game_over, winner,
               st, p1, p2, stp, go, win);
  endtask

  typedef struct {
    bit r, sv, a, b;
    logic [1:0] st;
    int p1, p2;
    bit stp, go, win;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input bit sv, input bit a, input bit b, input logic [1:0] st,
                     input int p1, input int p2, input bit stp, input bit go, input bit win);
    vecs.push_back(vec_t'{r, sv, a, b, st, p1, p2, stp, go, win});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit r, sv, a, b;
    // Reset, then serve held for 10 cycles: a single launch.
    add(1,0,0,0, 0,0,0,0,0,0);
    add(1,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0, 1,0,0,1,0,0);
    for (int i = 0; i < 9; i++) add(0,1,0,0, 1,0,0,0,0,0);
    // Player-1 point, then auto-serve after 3 ticks.
    add(0,0,1,0, 2,1,0,0,0,0);
    for (int i = 0; i < 11; i++) add(0,0,0,0, 2,1,0,0,0,0);
    add(0,0,0,0, 1,1,0,1,0,0);
    // Simultaneous points: player 1 only.
    add(0,0,1,1, 2,2,0,0,0,0);
    // Player 2 scores three times with serves in between.
    add(0,1,0,0, 1,2,0,1,0,0);
    add(0,0,0,1, 2,2,1,0,0,0);
    add(0,1,0,0, 1,2,1,1,0,0);
    add(0,0,0,1, 2,2,2,0,0,0);
    add(0,1,0,0, 1,2,2,1,0,0);
    add(0,0,0,1, 3,2,3,0,1,1);
    add(0,0,1,0, 3,2,3,0,1,1);
    // Serves during the hold are ignored; the first after it returns to IDLE.
    add(0,1,0,0, 3,2,3,0,1,1);
    add(0,0,0,0, 3,2,3,0,1,1);
    add(0,0,0,0, 3,2,3,0,1,1);
    add(0,1,0,0, 3,2,3,0,1,1);
    add(0,0,0,0, 3,2,3,0,1,1);
    add(0,1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0, 0,0,0,0,0,1);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].sv, vecs[i].a, vecs[i].b);
      expect_out($sformatf("vec[%0d]", i), vecs[i].st, vecs[i].p1, vecs[i].p2,
                 vecs[i].stp, vecs[i].go, vecs[i].win);
    end

    // Serve edge and timeout in the same cycle: one pulse.
    step(0,1,0,0); expect_out("coinc_launch0", 1, 0, 0, 1, 0, 1);
    step(0,0,1,0); expect_out("coinc_point",   2, 1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0,0,0,0); expect_out("coinc_wait", 2, 1, 0, 0, 0, 1);
    end
    step(0,1,0,0); expect_out("coinc_launch", 1, 1, 0, 1, 0, 1);
    step(0,1,0,0); expect_out("coinc_nopulse1", 1, 1, 0, 0, 0, 1);
    step(0,0,0,0); expect_out("coinc_nopulse2", 1, 1, 0, 0, 0, 1);

    // Reset in WAIT_SERVE with p1=2, serve held across reset release.
    step(0,0,1,0); expect_out("pre_reset", 2, 2, 0, 0, 0, 1);
    step(1,1,0,0); expect_out("reset_wait", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0,1,0,0); expect_out("held_serve", 0, 0, 0, 0, 0, 0);
    end
    // Reset during the stop_ball pulse.
    step(0,0,0,0); expect_out("idle_again", 0, 0, 0, 0, 0, 0);
    step(0,1,0,0); expect_out("launch_b", 1, 0, 0, 1, 0, 0);
    step(1,0,0,0); expect_out("reset_pulse", 0, 0, 0, 0, 0, 0);

    // Random stimulus against the reference model.
    step(1,0,0,0);
    sv = 0; a = 0; b = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) sv = ~sv;
      a = ($urandom_range(0, 11) == 0) ? ~a : a;
      b = ($urandom_range(0, 11) == 0) ? ~b : b;
      step(r, sv, a, b);
      expect_out($sformatf("rand[%0d]", i), 2'(m_st), m_p1, m_p2,
                 m_stop[0], (m_st == 3), m_win[0]);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
